// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared fetch FSM states, NOP and opcode constants, IF/ID slot type and J-immediate decode
package fetch_stage_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} fetch_state_e;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;
  function automatic logic [31:0] j_imm(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: imem request/response, execute redirect and IF/ID valid/ready bundle; master=fetch stage, slave=memory/decode side
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  modport master (
    output imem_req, imem_addr, if_valid, if_inst, if_pc,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );
  modport slave (
    input  imem_req, imem_addr, if_valid, if_inst, if_pc,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: single-entry skid register; ports clk, rst, clr_i (highest priority), load_i, pop_i, data_i -> valid_o, data_o
module fetch_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q;
  logic [W-1:0] data_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) valid_q <= 1'b0;
    else if (load_i) valid_q <= 1'b1;
    else if (pop_i) valid_q <= 1'b0;
    if (load_i) data_q <= data_i;
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: one-outstanding instruction fetch into the IF/ID slot; ports clk, rst, bus (fetch_stage_if.master: imem_req/addr/rvalid/rdata, redirect_valid/pc, if_valid/ready/inst/pc); macro JAL_PREDECODE_EN predecodes JAL targets
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = fetch_stage_pkg::NOP_INST
) (
  input logic clk,
  input logic rst,
  fetch_stage_if.master bus
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, acc_inst, seq_pc, skid_data;
  if_id_t       slot_q, slot_d;
  logic         rv, rd, free, take_mem, to_skid, take_skid, skid_valid;
  assign rv        = bus.imem_rvalid;
  assign rd        = bus.redirect_valid;
  assign free      = !slot_q.valid || bus.if_ready;
  assign take_mem  = state_q == WAIT && rv && free;
  assign to_skid   = state_q == WAIT && rv && !free;
  assign take_skid = state_q == HOLD && skid_valid && free;
  assign acc_inst  = take_skid ? skid_data : bus.imem_rdata;
`ifdef JAL_PREDECODE_EN
  assign seq_pc = acc_inst[6:0] == OP_JAL ? pc_q + j_imm(acc_inst) : pc_q + 32'd4;
`else
  assign seq_pc = pc_q + 32'd4;
`endif
  fetch_skid_buf #(.W(32)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (rd),
    .load_i (to_skid),
    .pop_i  (take_skid),
    .data_i (bus.imem_rdata),
    .valid_o(skid_valid),
    .data_o (skid_data)
  );
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    slot_d  = slot_q;
    if (rd) begin
      pc_d         = bus.redirect_pc & ~32'h3;
      slot_d.valid = 1'b0;
      slot_d.inst  = NOP_INST;
      state_d      = (state_q == WAIT || state_q == DROP) && !rv ? DROP : IDLE;
    end else begin
      if (take_mem || take_skid) begin
        slot_d = '{inst: acc_inst, pc: pc_q, valid: 1'b1};
        pc_d   = seq_pc;
      end else if (slot_q.valid && bus.if_ready) begin
        slot_d.valid = 1'b0;
        slot_d.inst  = NOP_INST;
      end
      state_d = state_q == IDLE ? WAIT :
                state_q == WAIT ? (rv ? (free ? IDLE : HOLD) : WAIT) :
                state_q == HOLD ? (free ? IDLE : HOLD) :
                (rv ? IDLE : DROP);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      slot_q  <= '{inst: NOP_INST, pc: RESET_PC, valid: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      slot_q  <= slot_d;
    end
  end
  assign bus.imem_req  = state_q == IDLE && !rst && !rd;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = slot_q.valid;
  assign bus.if_inst   = slot_q.inst;
  assign bus.if_pc     = slot_q.pc;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a latency-configurable instruction memory model
module tb_fetch_stage;
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          jal_mode = 1'b0;
  int unsigned lat_cfg = 1;
  logic [2:0]  cnt;
  logic [31:0] maddr;
  logic [31:0] exp_addr[$];
  slot_t       exp_slot[$];

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a, input bit jm);
    return (jm && a == 32'h100) ? 32'h0100_00EF : a ^ 32'hA500_0000;
  endfunction

  always @(posedge clk) begin
    if (rst) cnt <= 3'd0;
    else if (bus.imem_req) begin
      cnt   <= lat_cfg[2:0];
      maddr <= bus.imem_addr;
    end else if (cnt != 3'd0) cnt <= cnt - 3'd1;
  end
  assign bus.imem_rvalid = cnt == 3'd1;
  assign bus.imem_rdata  = word(maddr, jal_mode);

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (bus.imem_req) begin
        checks++;
        if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL req_addr: got request to %h, required no request", bus.imem_addr);
        end else begin
          logic [31:0] a;
          a = exp_addr.pop_front();
          if (bus.imem_addr !== a) begin
            errors++;
            $display("FAIL req_addr: got %h, required %h", bus.imem_addr, a);
          end
        end
      end
      if (bus.if_valid && bus.if_ready) begin
        checks++;
        if (exp_slot.size() == 0) begin
          errors++;
          $display("FAIL deliver: got inst %h pc %h, required no delivery", bus.if_inst, bus.if_pc);
        end else begin
          slot_t s;
          s = exp_slot.pop_front();
          if (bus.if_inst !== s.inst || bus.if_pc !== s.pc) begin
            errors++;
            $display("FAIL deliver: got inst %h pc %h, required inst %h pc %h", bus.if_inst, bus.if_pc, s.inst, s.pc);
          end
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, act, exp);
    end
  endtask

  task automatic to_cycle(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset(input int lat, input bit jm, input bit rdy);
    mon_en = 1'b0;
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.if_ready = rdy;
    lat_cfg = lat;
    jal_mode = jm;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_valid", {31'b0, bus.if_valid}, 32'h0);
    chk("rst_inst", bus.if_inst, 32'h0000_0013);
    chk("rst_pc", bus.if_pc, 32'h100);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    mon_en = 1'b1;
  endtask

  task automatic end_phase(input int n);
    to_cycle(n);
    mon_en = 1'b0;
    chk("addr_left", exp_addr.size(), 32'h0);
    chk("slot_left", exp_slot.size(), 32'h0);
    exp_addr.delete();
    exp_slot.delete();
  endtask

  task automatic push_slot(input logic [31:0] a, input bit jm);
    exp_slot.push_back('{inst: word(a, jm), pc: a});
  endtask

  initial begin
    logic [31:0] jal_next;
    // sequential fetch at 1-cycle latency
    do_reset(1, 1'b0, 1'b1);
    exp_addr = '{32'h100, 32'h104, 32'h108};
    push_slot(32'h100, 1'b0);
    push_slot(32'h104, 1'b0);
    to_cycle(1);
    @(negedge clk);
    chk("first_valid_c1", {31'b0, bus.if_valid}, 32'h0);
    to_cycle(2);
    @(negedge clk);
    chk("first_valid_c2", {31'b0, bus.if_valid}, 32'h1);
    chk("first_pc", bus.if_pc, 32'h100);
    end_phase(6);
    // decode stall fills the skid, then drains in order
    do_reset(1, 1'b0, 1'b0);
    exp_addr = '{32'h100, 32'h104, 32'h108};
    push_slot(32'h100, 1'b0);
    push_slot(32'h104, 1'b0);
    for (int k = 2; k <= 6; k++) begin
      to_cycle(k);
      @(negedge clk);
      chk("stall_valid", {31'b0, bus.if_valid}, 32'h1);
      chk("stall_pc", bus.if_pc, 32'h100);
      chk("stall_inst", bus.if_inst, word(32'h100, 1'b0));
      if (k >= 4) chk("stall_noreq", {31'b0, bus.imem_req}, 32'h0);
    end
    to_cycle(7);
    bus.if_ready = 1'b1;
    end_phase(10);
    // redirect while waiting on a 3-cycle memory
    do_reset(3, 1'b0, 1'b1);
    exp_addr = '{32'h100, 32'h200, 32'h204};
    push_slot(32'h200, 1'b0);
    to_cycle(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    to_cycle(2);
    bus.redirect_valid = 1'b0;
    end_phase(9);
    // redirect together with rvalid and a consuming handshake
    do_reset(1, 1'b0, 1'b0);
    exp_addr = '{32'h100, 32'h104, 32'h300, 32'h304};
    push_slot(32'h100, 1'b0);
    push_slot(32'h300, 1'b0);
    to_cycle(3);
    bus.if_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h300;
    to_cycle(4);
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_valid", {31'b0, bus.if_valid}, 32'h0);
    chk("redir_nop", bus.if_inst, 32'h0000_0013);
    end_phase(7);
    // unaligned redirect targets and pc wrap
    do_reset(1, 1'b0, 1'b1);
    exp_addr = '{32'hFFFF_FFFC, 32'h0, 32'h200, 32'h204};
    push_slot(32'hFFFF_FFFC, 1'b0);
    push_slot(32'h200, 1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("idle_redir_noreq", {31'b0, bus.imem_req}, 32'h0);
    to_cycle(1);
    bus.redirect_valid = 1'b0;
    to_cycle(4);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h203;
    to_cycle(5);
    bus.redirect_valid = 1'b0;
    end_phase(8);
    // JAL x1,+16 at 0x100
`ifdef JAL_PREDECODE_EN
    jal_next = 32'h110;
`else
    jal_next = 32'h104;
`endif
    do_reset(1, 1'b1, 1'b1);
    exp_addr = '{32'h100, jal_next};
    push_slot(32'h100, 1'b1);
    end_phase(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder. Owns the PC and issues one-outstanding requests to instruction memory.
- Registers each returned word with its PC into the IF/ID boundary and presents it to decode with a valid/ready handshake.
- Handles decode back-pressure (stall) and execute-stage redirects (branch/jump flush). Killed slots show the canonical NOP.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction word driven on if_inst while the output is invalid (ADDI x0,x0,0).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  request strobe; memory accepts in the same cycle.
- imem_addr  out  32  word-aligned fetch address; bits [1:0] always 0.
- imem_rvalid  in  1  response valid, arrives 1 or more cycles after the accepting request.
- imem_rdata  in  32  instruction word, qualified by imem_rvalid.
- redirect_valid  in  1  execute-stage redirect (taken branch, JAL, JALR).
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- if_valid  out  1  IF/ID slot holds a live instruction.
- if_ready  in  1  decode consumes the slot this cycle when if_valid && if_ready.
- if_inst  out  32  instruction word to the decoder.
- if_pc  out  32  PC of if_inst.

Behaviour:
- Reset (synchronous, rst high at the clock edge): pc <= RESET_PC, state <= IDLE, if_valid=0, if_inst=NOP_INST, if_pc=RESET_PC, imem_req=0.
- imem_addr always equals the pc register.
- States:
  - IDLE: imem_req=1, transition to WAIT. This is the first cycle after reset release.
  - WAIT: one request outstanding, imem_req=0.
    - On imem_rvalid with the slot free or consumed this cycle: load if_inst=imem_rdata and if_pc=pc, set if_valid=1, pc<=pc+4, then go to IDLE to issue the next request.
    - On imem_rvalid with the slot occupied and not consumed: hold the word in the skid register and go to HOLD.
  - HOLD: the skid word is waiting. When the slot frees, move the skid word into the slot, pc<=pc+4, go to IDLE.
  - DROP: a stale response is outstanding. On imem_rvalid, discard it and go to IDLE, fetching from the already-updated pc.
- Throughput: one instruction per 2 cycles at 1-cycle memory latency. Fetch-to-if_valid latency is 2 cycles from reset release.
- Redirect (has priority over every other event in the same cycle):
  - pc <= {redirect_pc[31:2],2'b00}; if_valid <= 0; if_inst <= NOP_INST; skid cleared.
  - From WAIT, if imem_rvalid is not present in the same cycle, go to DROP. Otherwise the response is discarded and the next state is IDLE.
  - From IDLE or HOLD, go to IDLE.
  - A redirect in the same cycle as if_ready && if_valid: the consumed slot is not re-presented.
- Stall: while if_valid && !if_ready, if_inst, if_pc and if_valid are held stable. No new request issues once the skid is full.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- rst asserted mid-operation (including in DROP) discards any outstanding response; state returns to IDLE.

Optional Feature:
- Macro: JAL_PREDECODE_EN.
- Defined: when a word accepted into the slot has opcode 7'b1101111, the next pc is if_pc + the sign-extended J-immediate instead of pc+4. The execute redirect still overrides it.
- Undefined: all sequential fetch is pc+4, and JAL relies on the execute redirect.

Decomposition:
- Shared package holds: fetch state enum (IDLE, WAIT, HOLD, DROP), NOP_INST, opcode constants (OP_JAL etc.), and a typedef if_id_t {inst, pc, valid}.
- One natural sub-module: fetch_skid_buf, a single-entry skid register with valid flag.

Test Plan:
- Reset with RESET_PC=32'h100, memory at 1-cycle latency, if_ready=1 -> imem_addr sequence 100,104,108. if_valid first high 2 cycles after reset release with if_pc=32'h100.
- Hold if_ready=0 for 5 cycles after the first instruction -> if_inst/if_pc stable, exactly one word in skid, no further imem_req. Release -> words for 100 and 104 delivered in order with no loss or duplicate.
- Redirect to 32'h200 while in WAIT with a 3-cycle memory -> stale response dropped, next imem_addr=200, next if_pc=200.
- Redirect in the same cycle as imem_rvalid and if_ready -> response discarded, if_valid=0, if_inst=32'h0000_0013, next fetch from the target.
- Redirect to 32'h203 -> imem_addr=32'h200. Starting from pc=32'hFFFF_FFFC -> next pc=32'h0.
- With JAL_PREDECODE_EN defined, fetch JAL x1,+16 at 32'h100 -> next imem_addr=32'h110. Without the macro -> 32'h104.
